// File: rtl/vending_controller.sv
// vending_controller: coin-operated vending FSM with per-channel stock,
// credit tracking, refund/timeout payout and restock.
//
// Ports:
//   clk          rising-edge clock
//   clr          synchronous active-high reset
//   coin1/coin2  coin strobes; rising edge adds COIN1_VAL / COIN2_VAL
//   buy          rise = purchase request, fall = end of dispense
//   refund       rise = return all credit
//   select       one-hot product select, sampled on buy rise
//   load         one-hot restock request
//   money        current credit
//   products     one-hot dispense indication (held while vending)
//   outofstock   registered per-channel empty flags
//   change_valid one-cycle payout strobe; change_amt holds the last payout
//   coin_reject  one-cycle pulse when a coin would overflow the credit
//   error        one-cycle pulse on a rejected purchase
module vending_controller #(
  parameter int unsigned NPROD       = 4,
  parameter int unsigned MONEY_W     = 12,
  parameter int unsigned STOCK_W     = 4,
  parameter logic [NPROD*MONEY_W-1:0] PRICES = {12'd200, 12'd150, 12'd75, 12'd25},
  parameter int unsigned COIN1_VAL   = 25,
  parameter int unsigned COIN2_VAL   = 100,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               coin1,
  input  logic               coin2,
  input  logic               buy,
  input  logic               refund,
  input  logic [NPROD-1:0]   select,
  input  logic [NPROD-1:0]   load,
  output logic [MONEY_W-1:0] money,
  output logic [NPROD-1:0]   products,
  output logic [NPROD-1:0]   outofstock,
  output logic               change_valid,
  output logic [MONEY_W-1:0] change_amt,
  output logic               coin_reject,
  output logic               error
);

  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

  localparam logic [MONEY_W:0] C1_VAL = (MONEY_W+1)'(COIN1_VAL);
  localparam logic [MONEY_W:0] C2_VAL = (MONEY_W+1)'(COIN2_VAL);

  state_t             state;
  logic [STOCK_W-1:0] stock [NPROD];
  logic               coin1_prev, coin2_prev, buy_prev, refund_prev;
  logic [31:0]        idle_cnt;

  logic               coin1_rise, coin2_rise, buy_rise, buy_fall, refund_rise;
  logic [MONEY_W:0]   sum1, sum2;
  logic [MONEY_W-1:0] price_sel;
  logic [STOCK_W-1:0] stock_sel;
  logic               buy_ok, load_ok, timeout_hit;

  assign coin1_rise  = coin1  & ~coin1_prev;
  assign coin2_rise  = coin2  & ~coin2_prev;
  assign buy_rise    = buy    & ~buy_prev;
  assign buy_fall    = ~buy   &  buy_prev;
  assign refund_rise = refund & ~refund_prev;

  // One extra bit catches credit overflow.
  assign sum1 = {1'b0, money} + C1_VAL;
  assign sum2 = {1'b0, money} + C2_VAL;

  always_comb begin
    price_sel = '0;
    stock_sel = '0;
    for (int unsigned i = 0; i < NPROD; i++) begin
      if (select[i]) begin
        price_sel = PRICES[i*MONEY_W +: MONEY_W];
        stock_sel = stock[i];
      end
    end
  end

  assign buy_ok      = $onehot(select) && (stock_sel != '0) && (money >= price_sel);
  assign load_ok     = $onehot(load);
  assign timeout_hit = (TIMEOUT_CYC != 0) && ((idle_cnt + 32'd1) >= TIMEOUT_CYC);

  always_ff @(posedge clk) begin
    if (clr) begin
      state        <= IDLE;
      money        <= '0;
      products     <= '0;
      outofstock   <= '0;
      change_valid <= 1'b0;
      change_amt   <= '0;
      coin_reject  <= 1'b0;
      error        <= 1'b0;
      idle_cnt     <= '0;
      // Prev registers reset high so inputs held through reset are not edges.
      coin1_prev   <= 1'b1;
      coin2_prev   <= 1'b1;
      buy_prev     <= 1'b1;
      refund_prev  <= 1'b1;
      for (int unsigned i = 0; i < NPROD; i++) stock[i] <= '1;
    end else begin
      coin1_prev   <= coin1;
      coin2_prev   <= coin2;
      buy_prev     <= buy;
      refund_prev  <= refund;
      coin_reject  <= 1'b0;
      error        <= 1'b0;
      change_valid <= 1'b0;
      idle_cnt     <= '0;
      for (int unsigned i = 0; i < NPROD; i++) outofstock[i] <= (stock[i] == '0);

      if (state == CHANGE) state <= IDLE;

      // Single priority chain: the first present edge consumes the cycle,
      // even when the current state ignores it.
      if (coin1_rise) begin
        if (sum1[MONEY_W]) coin_reject <= 1'b1;
        else               money       <= sum1[MONEY_W-1:0];
      end else if (coin2_rise) begin
        if (sum2[MONEY_W]) coin_reject <= 1'b1;
        else               money       <= sum2[MONEY_W-1:0];
      end else if (buy_rise) begin
        if (state == IDLE) begin
          if (buy_ok) begin
            products <= select;
            money    <= money - price_sel;
            state    <= VEND;
            for (int unsigned i = 0; i < NPROD; i++)
              if (select[i]) stock[i] <= stock[i] - STOCK_W'(1);
          end else begin
            error <= 1'b1;
          end
        end
      end else if (buy_fall) begin
        if (state == VEND) begin
          products <= '0;
          state    <= IDLE;
        end
      end else if (refund_rise) begin
        if (state == IDLE && money != '0) begin
          change_amt   <= money;
          money        <= '0;
          change_valid <= 1'b1;
          state        <= CHANGE;
        end
      end else if (state == IDLE) begin
        if (money != '0 && timeout_hit) begin
          change_amt   <= money;
          money        <= '0;
          change_valid <= 1'b1;
          state        <= CHANGE;
        end else if (load_ok) begin
          for (int unsigned i = 0; i < NPROD; i++)
            if (load[i]) stock[i] <= '1;
        end else if (money != '0) begin
          idle_cnt <= idle_cnt + 32'd1;
        end
      end
    end
  end

endmodule
